// File: rtl/dcache_wt_direct_if.sv
// Bus bundle for the write-through data cache: pipeline load/store port plus
// the registered request/valid port toward byte-addressable data memory.
interface dcache_wt_direct_if #(
  parameter int ADDR_WIDTH = 32
);
  // Handshakes: the pipeline holds req/we/address/byte_en/wdata stable while
  // stall=1 and the access completes in the first cycle with stall=0; toward
  // memory, mem_* outputs stay constant while mem_req=1 and the transaction
  // completes in the single cycle mem_valid=1 (mem_valid is ignored otherwise).
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] address;
  logic [3:0]            byte_en;
  logic [31:0]           wdata;
  logic                  flush;
  logic [31:0]           rdata;
  logic                  stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [3:0]            mem_byte_en;
  logic [31:0]           mem_wdata;
  logic                  mem_valid;
  logic [31:0]           mem_rdata;

  modport slave (
    input  req, we, address, byte_en, wdata, flush, mem_valid, mem_rdata,
    output rdata, stall, mem_req, mem_we, mem_address, mem_byte_en, mem_wdata
  );

  modport master (
    output req, we, address, byte_en, wdata, flush, mem_valid, mem_rdata,
    input  rdata, stall, mem_req, mem_we, mem_address, mem_byte_en, mem_wdata
  );
endinterface

// File: rtl/dcache_wt_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word
// lines; read hits complete combinationally, misses and stores go to memory.
module dcache_wt_direct #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  dcache_wt_direct_if.slave   bus,
  output logic [1:0]          dbg_state,
  output logic                dbg_flush_pending
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_WIDTH - 2 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  flush_pending_q, flush_pending_d;
  logic                  store_hit_q, store_hit_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [3:0]            mem_byte_en_q, mem_byte_en_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;

  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];

  logic [INDEX_W-1:0]    lk_index;
  logic [TAG_W-1:0]      lk_tag;
  logic                  hit;
  logic                  done;
  logic                  clear_all;
  logic                  fill;
  logic                  merge;
  logic                  unused_addr_bits;

  // The pipeline holds its address stable for the whole transaction, so the
  // live address also names the line to refill or merge at completion.
  assign lk_index         = bus.address[2 +: INDEX_W];
  assign lk_tag           = bus.address[ADDR_WIDTH-1 -: TAG_W];
  assign hit              = bus.req & valid_q[lk_index] & (tag_q[lk_index] == lk_tag);
  assign done             = bus.mem_valid & mem_req_q;
  assign unused_addr_bits = ^bus.address[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      flush_pending_q <= 1'b0;
      store_hit_q     <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_address_q   <= '0;
      mem_byte_en_q   <= '0;
      mem_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= flush_pending_d;
      store_hit_q     <= store_hit_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_address_q   <= mem_address_d;
      mem_byte_en_q   <= mem_byte_en_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    flush_pending_d = flush_pending_q;
    store_hit_d     = store_hit_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_address_d   = mem_address_q;
    mem_byte_en_d   = mem_byte_en_q;
    mem_wdata_d     = mem_wdata_q;
    bus.stall       = 1'b0;
    bus.rdata       = '0;
    clear_all       = 1'b0;
    fill            = 1'b0;
    merge           = 1'b0;

    case (state_q)
      IDLE: begin
        clear_all = bus.flush;
        if (bus.req) begin
          if (bus.we) begin
            bus.stall     = 1'b1;
            state_d       = WRITE;
            store_hit_d   = hit;
            mem_req_d     = 1'b1;
            mem_we_d      = 1'b1;
            mem_address_d = {bus.address[ADDR_WIDTH-1:2], 2'b00};
            mem_byte_en_d = bus.byte_en;
            mem_wdata_d   = bus.wdata;
          end else if (hit) begin
            bus.rdata = data_q[lk_index];
          end else begin
            bus.stall     = 1'b1;
            state_d       = FETCH;
            mem_req_d     = 1'b1;
            mem_we_d      = 1'b0;
            mem_address_d = {bus.address[ADDR_WIDTH-1:2], 2'b00};
            mem_byte_en_d = '0;
            mem_wdata_d   = '0;
          end
        end
      end

      FETCH, WRITE: begin
        if (bus.flush) flush_pending_d = 1'b1;
        if (done) begin
          // A flush seen at any point during the transaction wins over the refill.
          clear_all       = flush_pending_q | bus.flush;
          flush_pending_d = 1'b0;
          fill            = (state_q == FETCH);
          merge           = (state_q == WRITE) & store_hit_q;
          state_d         = IDLE;
          mem_req_d       = 1'b0;
          mem_we_d        = 1'b0;
          if (state_q == FETCH) bus.rdata = bus.mem_rdata;
        end else begin
          bus.stall = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[lk_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[lk_index] <= bus.mem_rdata;
      tag_q[lk_index]  <= lk_tag;
    end else if (merge) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_byte_en_q[k]) data_q[lk_index][8*k +: 8] <= mem_wdata_q[8*k +: 8];
      end
    end
  end

  assign bus.mem_req        = mem_req_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_byte_en    = mem_byte_en_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign dbg_state          = state_q;
  assign dbg_flush_pending  = flush_pending_q;
endmodule
